// File: rtl/core_pkg.sv
// Shared definitions for the RV32 base-integer core: sequencer states and opcode constants.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        TRAP  = 3'd4
    } state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam logic [6:0]  OP     = 7'b0110011;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  LUI    = 7'b0110111;
    localparam logic [6:0]  AUIPC  = 7'b0010111;

endpackage

// File: rtl/retire_cnt.sv
// Enable-gated free-running counter, wraps at 2^W.
// Latency: count reflects an enable on the following cycle.
// Backpressure: none; counts every cycle en is high.
module retire_cnt #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/exec sequencer owning PC and IR; RETIRE_CNT_EN adds the instret counter.
// Latency: 3 cycles per instruction minimum (FETCH accept, WAIT response, one EXEC cycle).
// Backpressure: fetch request held stable until imem_req_ready; WAIT stalls indefinitely on imem_rsp_valid.
module core_seq
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    input  logic            dec_reg_write,
    output logic            rf_we,
    input  logic            halt_req,
    output logic            halted,
    output logic            trap,
    output logic [63:0]     instret
);

    state_t state;

    assign imem_addr = pc;
    // Writeback only in the single EXEC cycle; an illegal opcode already has dec_reg_write low.
    assign rf_we     = (state == EXEC) && dec_reg_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            instr          <= NOP;
            imem_req_valid <= 1'b0;
            halted         <= 1'b0;
            trap           <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Out of reset valid is low, so the first FETCH cycle only raises it.
                    if (!imem_req_valid) begin
                        imem_req_valid <= 1'b1;
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr <= imem_rsp_data;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!dec_reg_write) begin
                        trap  <= 1'b1;
                        state <= TRAP;
                    end else begin
                        pc <= pc + XLEN'(4);
                        if (halt_req) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_req_valid <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        halted         <= 1'b0;
                        imem_req_valid <= 1'b1;
                        state          <= FETCH;
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    trap  <= 1'b1;
                    state <= TRAP;
                end
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic retire;

    assign retire = (state == EXEC) && dec_reg_write;

    retire_cnt #(
        .W(64)
    ) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire),
        .count (instret)
    );
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq: fetch timing, stall, spurious response, halt, trap, PC wrap.
module tb_core_seq;

    localparam logic [31:0] ADDI    = 32'h0010_0093;
    localparam logic [31:0] NOP_W   = 32'h0000_0013;
`ifdef RETIRE_CNT_EN
    localparam bit          RC_EN   = 1'b1;
`else
    localparam bit          RC_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        req_valid0, req_ready0, rsp_valid0, dec0, rf_we0, halt_req0, halted0, trap0;
    logic [31:0] addr0, rsp_data0, instr0, pc0;
    logic [63:0] instret0;

    logic        req_valid1, req_ready1, rsp_valid1, dec1, rf_we1, halt_req1, halted1, trap1;
    logic [31:0] addr1, rsp_data1, instr1, pc1;
    logic [63:0] instret1;

    int checks   = 0;
    int failures = 0;

    function automatic logic legal(input logic [31:0] w);
        case (w[6:0])
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    assign dec0 = legal(instr0);
    assign dec1 = legal(instr1);

    core_seq #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid0),
        .imem_req_ready (req_ready0),
        .imem_addr      (addr0),
        .imem_rsp_valid (rsp_valid0),
        .imem_rsp_data  (rsp_data0),
        .instr          (instr0),
        .pc             (pc0),
        .dec_reg_write  (dec0),
        .rf_we          (rf_we0),
        .halt_req       (halt_req0),
        .halted         (halted0),
        .trap           (trap0),
        .instret        (instret0)
    );

    core_seq #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid1),
        .imem_req_ready (req_ready1),
        .imem_addr      (addr1),
        .imem_rsp_valid (rsp_valid1),
        .imem_rsp_data  (rsp_data1),
        .instr          (instr1),
        .pc             (pc1),
        .dec_reg_write  (dec1),
        .rf_we          (rf_we1),
        .halt_req       (halt_req1),
        .halted         (halted1),
        .trap           (trap1),
        .instret        (instret1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in a FETCH cycle with valid high and ready high; ends in the cycle after EXEC.
    task automatic run_instr(input logic [31:0] a, input logic [31:0] w,
                             input logic we, input int extra_wait);
        chk("fetch_vld", req_valid0, 1);
        chk("fetch_addr", addr0, a);
        chk("fetch_we", rf_we0, 0);
        step();
        for (int i = 0; i <= extra_wait; i++) begin
            chk("wait_vld", req_valid0, 0);
            chk("wait_we", rf_we0, 0);
            if (i == extra_wait) begin
                rsp_valid0 = 1'b1;
                rsp_data0  = w;
            end
            step();
        end
        rsp_valid0 = 1'b0;
        chk("exec_instr", instr0, w);
        chk("exec_we", rf_we0, we);
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_ready0 = 1'b0; rsp_valid0 = 1'b0; rsp_data0 = 32'h0; halt_req0 = 1'b0;
        req_ready1 = 1'b0; rsp_valid1 = 1'b0; rsp_data1 = 32'h0; halt_req1 = 1'b0;

        #12;
        chk("rst_vld", req_valid0, 0);
        chk("rst_we", rf_we0, 0);
        chk("rst_halted", halted0, 0);
        chk("rst_trap", trap0, 0);
        chk("rst_instret", instret0, 0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_instr", instr0, NOP_W);
        chk("rst_pc_hi", pc1, 32'hFFFF_FFFC);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Stalled request with a spurious response injected during FETCH.
        for (int i = 0; i < 4; i++) begin
            chk("stall_vld", req_valid0, 1);
            chk("stall_addr", addr0, 32'h0);
            chk("stall_we", rf_we0, 0);
            chk("stall_instr", instr0, NOP_W);
            rsp_valid0 = (i == 1);
            rsp_data0  = 32'hFFFF_FFFF;
            step();
        end
        rsp_valid0 = 1'b0;
        chk("spurious_instr", instr0, NOP_W);

        req_ready0 = 1'b1;
        run_instr(32'h0, ADDI, 1'b1, 2);
        run_instr(32'h4, ADDI, 1'b1, 0);
        run_instr(32'h8, ADDI, 1'b1, 0);
        chk("seq_pc", pc0, 32'hC);
        chk("seq_instret", instret0, RC_EN ? 64'd3 : 64'd0);

        // Halt after the instruction at pc=12.
        halt_req0 = 1'b1;
        run_instr(32'hC, ADDI, 1'b1, 0);
        chk("halt_halted", halted0, 1);
        chk("halt_vld", req_valid0, 0);
        chk("halt_pc", pc0, 32'h10);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt_hold", halted0, 1);
            chk("halt_nofetch", req_valid0, 0);
        end
        halt_req0 = 1'b0;
        step();
        chk("resume_halted", halted0, 0);

        // Illegal word at pc=16 traps.
        run_instr(32'h10, 32'h0000_0000, 1'b0, 0);
        chk("trap_flag", trap0, 1);
        chk("trap_pc", pc0, 32'h10);
        chk("trap_instret", instret0, RC_EN ? 64'd4 : 64'd0);
        for (int i = 0; i < 3; i++) begin
            rsp_valid0 = 1'b1;
            rsp_data0  = ADDI;
            step();
            chk("trap_sticky", trap0, 1);
            chk("trap_nofetch", req_valid0, 0);
            chk("trap_pc_hold", pc0, 32'h10);
            chk("trap_we", rf_we0, 0);
        end
        rsp_valid0 = 1'b0;

        rst_n = 1'b0;
        #1;
        chk("rerst_trap", trap0, 0);
        chk("rerst_pc", pc0, 32'h0);
        chk("rerst_vld", req_valid0, 0);
        chk("rerst_instr", instr0, NOP_W);
        chk("rerst_instret", instret0, 0);
        step();
        rst_n = 1'b1;
        step();

        // PC wrap from 2^32-4 to 0.
        req_ready1 = 1'b1;
        chk("wrap_vld", req_valid1, 1);
        chk("wrap_addr", addr1, 32'hFFFF_FFFC);
        step();
        rsp_valid1 = 1'b1;
        rsp_data1  = ADDI;
        step();
        rsp_valid1 = 1'b0;
        chk("wrap_we", rf_we1, 1);
        step();
        chk("wrap_next_vld", req_valid1, 1);
        chk("wrap_next_addr", addr1, 32'h0);
        chk("wrap_trap", trap1, 0);
        chk("wrap_instret", instret1, RC_EN ? 64'd1 : 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
